zjh_univ_shreg: RTL and testbench



---
 rtl/zjh_shreg_pkg.sv | 33 +++
 rtl/zjh_univ_shreg_if.sv | 30 +++
 rtl/zjh_shreg_next.sv | 29 ++
 rtl/zjh_univ_shreg.sv | 84 ++++++++
 tb/tb_zjh_univ_shreg.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/zjh_shreg_pkg.sv
// Shared encodings for the universal shift register: manual modes, burst ops
// and the two-state burst sequencer.
package zjh_shreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SR   = 3'b001;
  localparam logic [2:0] MODE_SL   = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_RR   = 3'b100;
  localparam logic [2:0] MODE_RL   = 3'b101;

  localparam logic [1:0] BOP_SR = 2'b00;
  localparam logic [1:0] BOP_SL = 2'b01;
  localparam logic [1:0] BOP_RR = 2'b10;
  localparam logic [1:0] BOP_RL = 2'b11;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Burst ops reuse the manual datapath, so translate them to a Mode code.
  function automatic logic [2:0] burst_mode(input logic [1:0] bop);
    logic [2:0] m;
    case (bop)
      BOP_SR:  m = MODE_SR;
      BOP_SL:  m = MODE_SL;
      BOP_RR:  m = MODE_RR;
      default: m = MODE_RL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/zjh_univ_shreg_if.sv
// Control/data bundle of the universal shift register; the controller drives
// through master, the register itself sits on slave.
interface zjh_univ_shreg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             En;
  logic [2:0]       Mode;
  logic             DSR;
  logic             DSL;
  logic [WIDTH-1:0] Din;
  logic             Start;
  logic [1:0]       BurstOp;
  logic [CNT_W-1:0] Count;
  logic [WIDTH-1:0] Q;
  logic             SoutR;
  logic             SoutL;
  logic             Busy;
  logic             Done;

  modport master (
    output En, Mode, DSR, DSL, Din, Start, BurstOp, Count,
    input  Q, SoutR, SoutL, Busy, Done
  );

  modport slave (
    input  En, Mode, DSR, DSL, Din, Start, BurstOp, Count,
    output Q, SoutR, SoutL, Busy, Done
  );
endinterface

// File: rtl/zjh_shreg_next.sv
// Combinational next-state of the register for one op; shared by the manual
// and burst paths so both use the same direction convention.
module zjh_shreg_next
  import zjh_shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             dsr_i,
  input  logic             dsl_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] q_o
);

  // "Right" moves bits toward the MSB, matching the 74HC194 heritage.
  always_comb begin
    case (op_i)
      MODE_SR:   q_o = {q_i[WIDTH-2:0], dsr_i};
      MODE_SL:   q_o = {dsl_i, q_i[WIDTH-1:1]};
      MODE_RR:   q_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_RL:   q_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_LOAD: q_o = din_i;
      MODE_HOLD: q_o = q_i;
      default:   q_o = q_i;
    endcase
  end

endmodule

// File: rtl/zjh_univ_shreg.sv
// Universal shift register with manual modes and an autonomous N-step
// shift/rotate burst under a Start/Busy/Done handshake.
module zjh_univ_shreg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic              Clk,
  input logic              MR,
  zjh_univ_shreg_if.slave  bus
);
  import zjh_shreg_pkg::*;

  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       bop_q, bop_d;
  logic             done_q, done_d;
  logic [2:0]       op_sel;

  assign op_sel = (state_q == ST_RUN) ? burst_mode(bop_q) : bus.Mode;

  zjh_shreg_next #(.WIDTH(WIDTH)) u_next (
    .q_i   (q_q),
    .op_i  (op_sel),
    .dsr_i (bus.DSR),
    .dsl_i (bus.DSL),
    .din_i (bus.Din),
    .q_o   (q_nxt)
  );

  // Done defaults low every edge so it clears even while En holds everything else.
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bop_d   = bop_q;
    done_d  = 1'b0;
    if (bus.En) begin
      if (state_q == ST_IDLE) begin
        if (bus.Start) begin
          if (bus.Count != '0) begin
            state_d = ST_RUN;
            cnt_d   = bus.Count;
            bop_d   = bus.BurstOp;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          q_d = q_nxt;
        end
      end else begin
        q_d   = q_nxt;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      q_q     <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bop_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bop_q   <= bop_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q     = q_q;
  assign bus.SoutR = q_q[WIDTH-1];
  assign bus.SoutL = q_q[0];
  assign bus.Busy  = (state_q == ST_RUN);
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_zjh_univ_shreg.sv
// Bench for zjh_univ_shreg (WIDTH=8): directed cases plus a randomized run,
// all checked against an arithmetic reference model.
module tb_zjh_univ_shreg;
  localparam int W  = 8;
  localparam int CW = 4;

  logic Clk;
  logic MR;

  zjh_univ_shreg_if #(.WIDTH(W), .CNT_W(CW)) bus();

  zjh_univ_shreg #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk (Clk),
    .MR  (MR),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] m_q;
  bit         m_busy;
  bit         m_done;
  int         m_rem;
  int         m_bop;
  int         bmap [4] = '{1, 2, 4, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input int op, input logic [7:0] q, input bit dsr,
                                        input bit dsl, input logic [7:0] din);
    int v;
    int r;
    v = int'(q);
    case (op)
      1:       r = (v * 2) % 256 + int'(dsr);
      2:       r = v / 2 + int'(dsl) * 128;
      3:       r = int'(din);
      4:       r = (v * 2) % 256 + v / 128;
      5:       r = v / 2 + (v % 2) * 128;
      default: r = v;
    endcase
    return r[7:0];
  endfunction

  task automatic model_reset();
    m_q    = 8'h00;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_rem  = 0;
    m_bop  = 0;
  endtask

  task automatic model_step();
    bit dn;
    dn = 1'b0;
    if (MR) begin
      model_reset();
    end else begin
      if (bus.En) begin
        if (!m_busy) begin
          if (bus.Start) begin
            if (bus.Count != 0) begin
              m_busy = 1'b1;
              m_rem  = int'(bus.Count);
              m_bop  = int'(bus.BurstOp);
            end else begin
              dn = 1'b1;
            end
          end else begin
            m_q = ref_op(int'(bus.Mode), m_q, bus.DSR, bus.DSL, bus.Din);
          end
        end else begin
          m_q = ref_op(bmap[m_bop], m_q, bus.DSR, bus.DSL, bus.Din);
          m_rem--;
          if (m_rem == 0) begin
            m_busy = 1'b0;
            dn     = 1'b1;
          end
        end
      end
      m_done = dn;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".Q"},     bus.Q,     m_q);
    chk({tag, ".Busy"},  bus.Busy,  m_busy);
    chk({tag, ".Done"},  bus.Done,  m_done);
    chk({tag, ".SoutR"}, bus.SoutR, m_q[7]);
    chk({tag, ".SoutL"}, bus.SoutL, m_q[0]);
  endtask

  task automatic tick(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit en, input logic [2:0] mode, input bit dsr, input bit dsl,
                        input logic [7:0] din, input bit start, input logic [1:0] bop,
                        input logic [3:0] cnt);
    bus.En      = en;
    bus.Mode    = mode;
    bus.DSR     = dsr;
    bus.DSL     = dsl;
    bus.Din     = din;
    bus.Start   = start;
    bus.BurstOp = bop;
    bus.Count   = cnt;
  endtask

  task automatic load(input logic [7:0] v);
    set_in(1, 3'b011, 0, 0, v, 0, 2'b00, 4'd0);
    tick("load");
  endtask

  task automatic hold_in();
    set_in(1, 3'b000, 0, 0, 8'h00, 0, 2'b00, 4'd0);
  endtask

  // Reset asserted between edges; optionally held across one clock edge.
  task automatic pulse_mr(input bit hold_edge);
    #2;
    MR = 1'b1;
    #1;
    model_reset();
    check_all("mr_async");
    chk("mr_async_q", bus.Q, 8'h00);
    chk("mr_async_busy", bus.Busy, 1'b0);
    if (hold_edge) begin
      tick("mr_held");
      chk("mr_held_q", bus.Q, 8'h00);
    end
    MR = 1'b0;
  endtask

  initial begin
    MR = 1'b1;
    set_in(0, 3'b000, 0, 0, 8'h00, 0, 2'b00, 4'd0);
    model_reset();
    #2;
    check_all("por");
    tick("por_edge");
    MR = 1'b0;

    load(8'hA5);
    chk("load_a5", bus.Q, 8'hA5);
    pulse_mr(1'b1);

    load(8'h81);
    set_in(1, 3'b001, 0, 0, 8'h00, 0, 2'b00, 4'd0);
    tick("sr");
    chk("sr_val", bus.Q, 8'h02);
    load(8'h81);
    set_in(1, 3'b100, 0, 0, 8'h00, 0, 2'b00, 4'd0);
    tick("rr");
    chk("rr_val", bus.Q, 8'h03);
    load(8'h81);
    set_in(1, 3'b101, 0, 0, 8'h00, 0, 2'b00, 4'd0);
    tick("rl");
    chk("rl_val", bus.Q, 8'hC0);
    load(8'h3C);
    chk("load_3c", bus.Q, 8'h3C);
    set_in(1, 3'b110, 1, 1, 8'hFF, 0, 2'b00, 4'd0);
    tick("hold110");
    chk("hold110_val", bus.Q, 8'h3C);

    // Rotate burst, with a stray Start and Mode=load during Busy.
    load(8'h01);
    set_in(1, 3'b000, 0, 0, 8'h00, 1, 2'b10, 4'd3);
    tick("b_start");
    chk("b_start_busy", bus.Busy, 1'b1);
    chk("b_start_q", bus.Q, 8'h01);
    set_in(1, 3'b011, 0, 0, 8'hFF, 1, 2'b01, 4'd5);
    tick("b_s1");
    chk("b_s1_q", bus.Q, 8'h02);
    hold_in();
    tick("b_s2");
    chk("b_s2_q", bus.Q, 8'h04);
    chk("b_s2_busy", bus.Busy, 1'b1);
    tick("b_s3");
    chk("b_s3_q", bus.Q, 8'h08);
    chk("b_s3_done", bus.Done, 1'b1);
    chk("b_s3_busy", bus.Busy, 1'b0);
    tick("b_after");
    chk("b_after_done", bus.Done, 1'b0);
    chk("b_after_busy", bus.Busy, 1'b0);

    // Burst shift with an En gap.
    load(8'h00);
    set_in(1, 3'b000, 1, 0, 8'h00, 1, 2'b00, 4'd2);
    tick("g_start");
    set_in(1, 3'b000, 1, 0, 8'h00, 0, 2'b00, 4'd0);
    tick("g_s1");
    chk("g_s1_q", bus.Q, 8'h01);
    bus.En = 1'b0;
    tick("g_pause");
    chk("g_pause_q", bus.Q, 8'h01);
    chk("g_pause_busy", bus.Busy, 1'b1);
    bus.En = 1'b1;
    tick("g_s2");
    chk("g_s2_q", bus.Q, 8'h03);
    chk("g_s2_done", bus.Done, 1'b1);
    bus.En = 1'b0;
    tick("g_done_clr");
    chk("g_done_clr", bus.Done, 1'b0);

    // Zero-length burst.
    load(8'h5A);
    set_in(1, 3'b010, 1, 1, 8'h00, 1, 2'b10, 4'd0);
    tick("c0");
    chk("c0_done", bus.Done, 1'b1);
    chk("c0_busy", bus.Busy, 1'b0);
    chk("c0_q", bus.Q, 8'h5A);
    hold_in();
    tick("c0_after");

    // Count larger than WIDTH wraps the rotate.
    load(8'h01);
    set_in(1, 3'b000, 0, 0, 8'h00, 1, 2'b10, 4'd9);
    tick("c9_start");
    hold_in();
    repeat (8) tick("c9_run");
    chk("c9_busy", bus.Busy, 1'b1);
    tick("c9_last");
    chk("c9_q", bus.Q, 8'h02);
    chk("c9_done", bus.Done, 1'b1);

    // Reset mid-burst aborts without Done.
    load(8'h01);
    set_in(1, 3'b000, 0, 0, 8'h00, 1, 2'b10, 4'd5);
    tick("ab_start");
    hold_in();
    tick("ab_s1");
    pulse_mr(1'b0);
    tick("ab_after1");
    chk("ab_done", bus.Done, 1'b0);
    tick("ab_after2");

    // Serial outputs.
    load(8'h80);
    chk("so_r", bus.SoutR, 1'b1);
    chk("so_l", bus.SoutL, 1'b0);
    set_in(1, 3'b010, 0, 0, 8'h00, 0, 2'b00, 4'd0);
    repeat (7) tick("so_sl");
    chk("so_l7", bus.SoutL, 1'b1);
    chk("so_q7", bus.Q, 8'h01);

    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 4) != 0, 3'($urandom % 8), 1'($urandom % 2), 1'($urandom % 2),
             8'($urandom), ($urandom % 4) == 0, 2'($urandom % 4), 4'($urandom % 11));
      tick("rnd");
      if (($urandom % 50) == 0) pulse_mr(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
